// File: rtl/pwm_pkg.sv
// Shared types, default widths and the duty stepping helper for the PWM ramp sequencer.
package pwm_pkg;

    localparam int unsigned DEF_BIT_WIDTH = 8;
    localparam int unsigned DEF_HOLD_W    = 16;
    localparam int unsigned STEP_CALC_W   = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RAMP = 2'd1,
        HOLD = 2'd2
    } state_e;

    // Next duty one step toward target, clamped to target so it never overshoots or wraps.
    // Callers zero-extend narrower operands, so the difference never wraps.
    function automatic logic [STEP_CALC_W-1:0] step_toward(
        input logic [STEP_CALC_W-1:0] duty,
        input logic [STEP_CALC_W-1:0] target,
        input logic [STEP_CALC_W-1:0] step
    );
        logic [STEP_CALC_W-1:0] diff;
        if (target >= duty) begin
            diff        = target - duty;
            step_toward = (diff <= step) ? target : duty + step;
        end else begin
            diff        = duty - target;
            step_toward = (diff <= step) ? target : duty - step;
        end
    endfunction

endpackage

// File: rtl/pwm_hold_counter.sv
// Counts PWM periods spent holding at the target duty.
module pwm_hold_counter
    import pwm_pkg::*;
#(
    parameter int unsigned HOLD_W = DEF_HOLD_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_i,
    input  logic              load_i,
    input  logic [HOLD_W-1:0] load_val_i,
    input  logic              dec_i,
    output logic              last_c
);

    logic [HOLD_W-1:0] cnt_q;
    logic [HOLD_W-1:0] cnt_d;

    // Next count: clear beats load, load beats decrement; never decrements below zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - HOLD_W'(1);
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_c = (cnt_q == HOLD_W'(1));

endmodule

// File: rtl/pwm_ramp_sequencer.sv
// Ramps the PWM duty toward a commanded target one step per PWM period, then holds it.
module pwm_ramp_sequencer
    import pwm_pkg::*;
#(
    parameter int unsigned          BIT_WIDTH  = DEF_BIT_WIDTH,
    parameter int unsigned          HOLD_W     = DEF_HOLD_W,
    parameter logic [BIT_WIDTH-1:0] RESET_DUTY = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 period_tick,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [BIT_WIDTH-1:0] cmd_target,
    input  logic [BIT_WIDTH-1:0] cmd_step,
    input  logic [HOLD_W-1:0]    cmd_hold,
    input  logic                 abort,
    output logic [BIT_WIDTH-1:0] duty,
    output logic                 busy,
    output logic                 done
);

    state_e                state_q,  state_d;
    logic [BIT_WIDTH-1:0]  duty_q,   duty_d;
    logic [BIT_WIDTH-1:0]  target_q, target_d;
    logic [BIT_WIDTH-1:0]  step_q,   step_d;
    logic [HOLD_W-1:0]     hold_q,   hold_d;
    logic                  busy_q,   busy_d;
    logic                  done_q,   done_d;

    logic                  hold_clear;
    logic                  hold_load;
    logic                  hold_dec;
    logic                  hold_last;
    logic [BIT_WIDTH-1:0]  next_duty;
    logic                  reached;

    // Candidate duty for the next period and whether it lands on the target.
    assign next_duty = BIT_WIDTH'(step_toward(STEP_CALC_W'(duty_q),
                                              STEP_CALC_W'(target_q),
                                              STEP_CALC_W'(step_q)));
    assign reached   = (next_duty == target_q);

    assign cmd_ready = (state_q == IDLE) && !abort;

    // Next-state, duty update and hold-counter control.
    always_comb begin
        state_d    = state_q;
        duty_d     = duty_q;
        target_d   = target_q;
        step_d     = step_q;
        hold_d     = hold_q;
        done_d     = 1'b0;
        hold_clear = 1'b0;
        hold_load  = 1'b0;
        hold_dec   = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    target_d = cmd_target;
                    step_d   = (cmd_step == '0) ? BIT_WIDTH'(1) : cmd_step;
                    hold_d   = cmd_hold;
                    state_d  = RAMP;
                end
            end
            RAMP: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (period_tick) begin
                    duty_d = next_duty;
                    if (reached) begin
                        if (hold_q == '0) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d   = HOLD;
                            hold_load = 1'b1;
                        end
                    end
                end
            end
            HOLD: begin
                if (abort) begin
                    state_d    = IDLE;
                    hold_clear = 1'b1;
                end else if (period_tick) begin
                    hold_dec = 1'b1;
                    if (hold_last) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State, duty, latched command and status registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            duty_q   <= RESET_DUTY;
            target_q <= '0;
            step_q   <= '0;
            hold_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            duty_q   <= duty_d;
            target_q <= target_d;
            step_q   <= step_d;
            hold_q   <= hold_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    pwm_hold_counter #(
        .HOLD_W (HOLD_W)
    ) u_hold_counter (
        .clk        (clk),
        .reset      (reset),
        .clear_i    (hold_clear),
        .load_i     (hold_load),
        .load_val_i (hold_q),
        .dec_i      (hold_dec),
        .last_c     (hold_last)
    );

    assign duty = duty_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_pwm_ramp_sequencer.sv
// Directed, table-driven bench for pwm_ramp_sequencer.
module tb_pwm_ramp_sequencer;

    localparam int unsigned BW = 8;
    localparam int unsigned HW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          period_tick;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [BW-1:0] cmd_target;
    logic [BW-1:0] cmd_step;
    logic [HW-1:0] cmd_hold;
    logic          abort;
    logic [BW-1:0] duty;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    pwm_ramp_sequencer #(
        .BIT_WIDTH  (BW),
        .HOLD_W     (HW),
        .RESET_DUTY (8'd0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .period_tick (period_tick),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_target  (cmd_target),
        .cmd_step    (cmd_step),
        .cmd_hold    (cmd_hold),
        .abort       (abort),
        .duty        (duty),
        .busy        (busy),
        .done        (done)
    );

    typedef struct {
        logic          rst;
        logic          tick;
        logic          vld;
        logic          abt;
        logic [BW-1:0] tgt;
        logic [BW-1:0] stp;
        logic [HW-1:0] hld;
        logic          e_rdy;
        logic [BW-1:0] e_duty;
        logic          e_busy;
        logic          e_done;
    } vec_t;

    vec_t vq[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic void add(input logic rst, input logic tick, input logic vld,
                                input logic abt, input int tgt, input int stp, input int hld,
                                input logic e_rdy, input int e_duty, input logic e_busy,
                                input logic e_done);
        vec_t v;
        v.rst    = rst;
        v.tick   = tick;
        v.vld    = vld;
        v.abt    = abt;
        v.tgt    = BW'(tgt);
        v.stp    = BW'(stp);
        v.hld    = HW'(hld);
        v.e_rdy  = e_rdy;
        v.e_duty = BW'(e_duty);
        v.e_busy = e_busy;
        v.e_done = e_done;
        vq.push_back(v);
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step=%0d got=%0d expected=%0d", name, idx, act, exp);
        end
    endtask

    initial begin
        int dcount;
        int done_cyc;
        logic prev_done;
        logic wide;
        logic [BW-1:0] duty_at_done;
        logic busy_at_done;

        reset       = 1'b1;
        period_tick = 1'b0;
        cmd_valid   = 1'b0;
        cmd_target  = '0;
        cmd_step    = '0;
        cmd_hold    = '0;
        abort       = 1'b0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("reset_duty",  -1, 32'(duty), 32'd0);
        chk("reset_busy",  -1, 32'(busy), 32'd0);
        chk("reset_done",  -1, 32'(done), 32'd0);
        chk("reset_ready", -1, 32'(cmd_ready), 32'd1);

        //   rst tick vld abt tgt stp hld | rdy duty busy done
        // Idle: five ticks with no command.
        for (int i = 0; i < 5; i++) add(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        // Up ramp 0 -> 40, step 10, hold 2.
        add(0, 0, 1, 0, 40, 10, 2, 1, 0, 1, 0);
        add(0, 1, 0, 0,  0,  0, 0, 0, 10, 1, 0);
        add(0, 0, 0, 0,  0,  0, 0, 0, 10, 1, 0);
        add(0, 1, 0, 0,  0,  0, 0, 0, 20, 1, 0);
        add(0, 1, 0, 0,  0,  0, 0, 0, 30, 1, 0);
        add(0, 1, 0, 0,  0,  0, 0, 0, 40, 1, 0);
        add(0, 1, 0, 0,  0,  0, 0, 0, 40, 1, 0);
        add(0, 1, 0, 0,  0,  0, 0, 0, 40, 0, 1);
        // Down ramp 40 -> 5, step 16, hold 0; accepted in the done cycle.
        add(0, 0, 1, 0,  5, 16, 0, 1, 40, 1, 0);
        add(0, 1, 0, 0,  0,  0, 0, 0, 24, 1, 0);
        add(0, 1, 0, 0,  0,  0, 0, 0,  8, 1, 0);
        add(0, 1, 0, 0,  0,  0, 0, 0,  5, 0, 1);
        add(0, 0, 0, 0,  0,  0, 0, 1,  5, 0, 0);
        // Jump to 250, then saturate to 255.
        add(0, 0, 1, 0, 250, 255, 0, 1,   5, 1, 0);
        add(0, 1, 0, 0,   0,   0, 0, 0, 250, 0, 1);
        add(0, 0, 1, 0, 255,  10, 0, 1, 250, 1, 0);
        add(0, 1, 0, 0,   0,   0, 0, 0, 255, 0, 1);
        // Step 0 is treated as 1.
        add(0, 0, 1, 0, 253,   0, 0, 1, 255, 1, 0);
        add(0, 1, 0, 0,   0,   0, 0, 0, 254, 1, 0);
        add(0, 1, 0, 0,   0,   0, 0, 0, 253, 0, 1);
        // Target equal to duty still ramps and exits on first tick.
        add(0, 0, 1, 0, 253,   5, 0, 1, 253, 1, 0);
        add(0, 1, 0, 0,   0,   0, 0, 0, 253, 0, 1);
        // Go to 20, then abort with a simultaneous tick while ramping to 60.
        add(0, 0, 1, 0,  20, 255, 0, 1, 253, 1, 0);
        add(0, 1, 0, 0,   0,   0, 0, 0,  20, 0, 1);
        add(0, 0, 1, 0,  60,  10, 3, 1,  20, 1, 0);
        add(0, 1, 0, 1,   0,   0, 0, 0,  20, 0, 0);
        add(0, 0, 1, 1,  99,   9, 0, 0,  20, 0, 0);
        add(0, 1, 0, 0,   0,   0, 0, 1,  20, 0, 0);
        // Command held during RAMP is ignored; reset mid-HOLD.
        add(0, 0, 1, 0,  30,   5, 2, 1,  20, 1, 0);
        add(0, 1, 1, 0, 200, 100, 0, 0,  25, 1, 0);
        add(0, 1, 1, 0, 200, 100, 0, 0,  30, 1, 0);
        add(0, 1, 0, 0,   0,   0, 0, 0,  30, 1, 0);
        add(1, 1, 0, 0,   0,   0, 0, 0,   0, 0, 0);
        add(0, 1, 0, 0,   0,   0, 0, 1,   0, 0, 0);
        add(0, 1, 0, 0,   0,   0, 0, 1,   0, 0, 0);

        foreach (vq[i]) begin
            @(negedge clk);
            reset       = vq[i].rst;
            period_tick = vq[i].tick;
            cmd_valid   = vq[i].vld;
            abort       = vq[i].abt;
            cmd_target  = vq[i].tgt;
            cmd_step    = vq[i].stp;
            cmd_hold    = vq[i].hld;
            #1;
            chk("cmd_ready", i, 32'(cmd_ready), 32'(vq[i].e_rdy));
            @(posedge clk);
            #1;
            chk("duty", i, 32'(duty), 32'(vq[i].e_duty));
            chk("busy", i, 32'(busy), 32'(vq[i].e_busy));
            chk("done", i, 32'(done), 32'(vq[i].e_done));
        end

        // Long ramp 0 -> 100 step 7, hold 1, ticks every third cycle; done must pulse once.
        @(negedge clk);
        reset       = 1'b0;
        period_tick = 1'b0;
        abort       = 1'b0;
        cmd_valid   = 1'b1;
        cmd_target  = 8'd100;
        cmd_step    = 8'd7;
        cmd_hold    = 16'd1;
        @(negedge clk);
        cmd_valid    = 1'b0;
        dcount       = 0;
        done_cyc     = 0;
        prev_done    = 1'b0;
        wide         = 1'b0;
        duty_at_done = '0;
        busy_at_done = 1'b1;
        for (int c = 0; c < 300; c++) begin
            if (c != 0) @(negedge clk);
            period_tick = (c % 3 == 0);
            @(posedge clk);
            #1;
            if (done) begin
                if (prev_done) wide = 1'b1;
                if (dcount == 0) begin
                    duty_at_done = duty;
                    busy_at_done = busy;
                    done_cyc     = c;
                end
                dcount++;
            end
            prev_done = done;
            if (dcount > 0 && c > done_cyc + 6) break;
        end
        period_tick = 1'b0;
        chk("long_done_count", 0, 32'(dcount), 32'd1);
        chk("long_done_width", 0, 32'(wide), 32'd0);
        chk("long_final_duty", 0, 32'(duty_at_done), 32'd100);
        chk("long_busy_at_done", 0, 32'(busy_at_done), 32'd0);
        chk("long_duty_after", 0, 32'(duty), 32'd100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
